// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one synchronous block ROM between two
// valid/ready requesters. A tag pipeline follows each accepted read through
// the ROM latency, so the returned data is steered back to its requester.
module rom_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  // One tag per pipeline stage: RD_LAT stages through the ROM plus the
  // stage that lines up with the registered rom_addr.
  localparam int TAGS = RD_LAT + 1;

  logic              grant0_s;
  logic              grant1_s;
  logic              accept_s;
  logic              grant_id_s;
  logic [ADDR_W-1:0] grant_addr_s;
  logic              out_vld_s;
  logic              out_id_s;

  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [TAGS-1:0]   tag_vld_q, tag_vld_d;
  logic [TAGS-1:0]   tag_id_q, tag_id_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

  // Round-robin grant: a lone requester always wins; under contention the
  // requester that was not granted last wins. Depends only on the valids
  // and the pointer, never on the response side.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01: grant0_s = 1'b1;
      2'b10: grant1_s = 1'b1;
      2'b11: begin
        if (last_grant_q) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end
      default: begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    endcase
  end

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign accept_s     = grant0_s | grant1_s;
  assign grant_id_s   = grant1_s;
  assign grant_addr_s = grant1_s ? req1_addr : req0_addr;

  // The oldest tag decides which requester receives the current ROM data.
  assign out_vld_s = tag_vld_q[TAGS-1];
  assign out_id_s  = tag_id_q[TAGS-1];

  // Next-state logic: pointer and ROM address move only on an accept so the
  // ROM port stays quiet when idle; tags shift every cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    rom_addr_d   = rom_addr_q;
    if (accept_s) begin
      last_grant_d = grant_id_s;
      rom_addr_d   = grant_addr_s;
    end else begin
      last_grant_d = last_grant_q;
      rom_addr_d   = rom_addr_q;
    end

    tag_vld_d = {tag_vld_q[TAGS-2:0], accept_s};
    tag_id_d  = {tag_id_q[TAGS-2:0], grant_id_s};

    rsp0_valid_d = out_vld_s & ~out_id_s;
    rsp1_valid_d = out_vld_s & out_id_s;

    rsp0_data_d = rsp0_data_q;
    if (rsp0_valid_d) begin
      rsp0_data_d = rom_data;
    end else begin
      rsp0_data_d = rsp0_data_q;
    end

    rsp1_data_d = rsp1_data_q;
    if (rsp1_valid_d) begin
      rsp1_data_d = rom_data;
    end else begin
      rsp1_data_d = rsp1_data_q;
    end
  end

  // State registers; reset discards every in-flight read.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rom_addr_q   <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rom_addr_q   <= rom_addr_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = |tag_vld_q;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares a single-port synchronous block ROM (5-bit address, 8-bit data) between two independent requesters. Requests use a valid/ready handshake and are granted round-robin, one per cycle. Each response is returned to its originating requester after a fixed, parameterised latency. The block sits between the ROM IP instance and the client logic; ROM address and data are also exported to the debug ILA.

## Interface
- ADDR_W, 5, ROM address width
- DATA_W, 8, ROM data width
- RD_LAT, 1, ROM read latency in cycles from address to valid douta; legal range 1..3

- sys_clk  in  1  single clock for the block and the ROM
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an address to read
- req0_addr  in  ADDR_W  requester 0 read address
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- rsp0_valid  out  1  requester 0 read data valid, one-cycle pulse
- rsp0_data  out  DATA_W  requester 0 read data
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data  same as requester 0, for requester 1
- rom_addr  out  ADDR_W  registered address to the ROM addra
- rom_data  in  DATA_W  ROM douta
- busy  out  1  at least one read in flight

## Operation
- Accept: reqN_valid & reqN_ready sampled at a rising edge.
- Grant, combinational per cycle:
  - One valid: that requester gets ready.
  - Both valid: the requester not granted last wins.
  - None valid: no ready.
  - At most one ready high per cycle.
- Round-robin pointer last_grant updates only on an accept. Reset value is 1, so requester 0 wins the first contention.
- Address path:
  - On accept, rom_addr <= granted addr.
  - Otherwise rom_addr holds its value (no ROM port toggling when idle).
- Tag pipeline: a shift register of RD_LAT+1 entries, each {valid, id}.
  - Entry 0 loads {accept, granted id} each edge.
  - Entries shift one per cycle.
  - The last entry's valid/id drive the response registers.
- Response: when the tag exits with valid=1:
  - rsp{id}_data <= rom_data
  - rsp{id}_valid <= 1 for exactly one cycle
  - The other requester's rsp_valid stays 0; its data holds.
- No response backpressure. Requesters must consume rsp on the cycle it is valid.
- busy = OR of all tag valid bits.
- Address wrap: addresses are plain ADDR_W values, so 31 followed by 0 needs no special handling. The arbiter does no address arithmetic.
- Requesters keep valid and addr stable until ready. Addr changes while waiting are used as-is on the granting cycle.
- Reset (async, any time):
  - rom_addr = 0, last_grant = 1
  - All tag valids = 0
  - rsp0/1_valid = 0, rsp0/1_data = 0, busy = 0
  - In-flight reads are discarded and never produce a response after reset release.

## Timing
- Accept at edge E0 → rom_addr valid from E0 → rom_data valid after E0+RD_LAT → rspN_valid/data registered at E0+RD_LAT+1.
- Latency is RD_LAT+1 cycles from the accepting edge to the response-valid cycle.
- Throughput: one accept per cycle, sustained, across both requesters combined.
- Responses return in accept order.
- reqN_ready depends only on both req valids and last_grant, with no path from the rsp outputs.
- busy is 1 from the cycle after the first accept until the cycle the last response is presented.

## Test plan
Bench ROM model: mem[a] = 8'hA0 + a, with RD_LAT honoured.

- **Single read:** RD_LAT=1; req0 valid, addr 3 for one cycle.
  - req0_ready=1 that cycle.
  - rsp0_valid pulses exactly 2 cycles after the accepting edge with rsp0_data=8'hA3.
  - rsp1_valid stays 0.
- **Contention:** both requesters valid continuously, req0 addr 5, req1 addr 9.
  - Grants alternate 0,1,0,1…, starting with 0 after reset.
  - Responses alternate 8'hA5 on rsp0 and 8'hA9 on rsp1, one per cycle.
- **Streaming with wrap:** req1 alone, addresses 30,31,0,1 back-to-back, RD_LAT=3.
  - Four consecutive rsp1_valid cycles starting 4 cycles after the first accept.
  - Data BE,BF,A0,A1.
- **Waiting requester:** req1 last granted, then req0 and req1 raise valid together.
  - req0 granted first.
  - req1 stays valid, addr held at 7, and is granted next cycle.
  - Its response, 8'hA7, arrives one cycle after req0's.
- **Reset mid-flight:** RD_LAT=2; two reads accepted, rst_n pulsed low 1 cycle before the first response.
  - All outputs 0 during reset.
  - No rsp_valid ever appears for the discarded reads.
  - First contention after release grants req0.
- **Idle hold:** after a read of addr 12, no requests for 10 cycles.
  - rom_addr stays 12.
  - busy falls after the response.
  - No spurious rsp_valid.
